// File: rtl/regfile_32x64_if.sv
// Register-file access bundle: one write port (one-hot select) and two read ports.
// The master drives the write and read addresses; the register file is the slave.
interface regfile_32x64_if #(
    parameter int WIDTH = 64
);
    logic             wr_en;
    logic [31:0]      wr_sel;
    logic [WIDTH-1:0] wr_data;
    logic [4:0]       rd_addr1;
    logic [4:0]       rd_addr2;
    logic [WIDTH-1:0] rd_data1;
    logic [WIDTH-1:0] rd_data2;
    logic             err_multi_hot;

    modport master (
        output wr_en, wr_sel, wr_data, rd_addr1, rd_addr2,
        input  rd_data1, rd_data2, err_multi_hot
    );

    modport slave (
        input  wr_en, wr_sel, wr_data, rd_addr1, rd_addr2,
        output rd_data1, rd_data2, err_multi_hot
    );
endinterface

// File: rtl/regfile_32x64.sv
// LEGv8 architectural register file: X0..X30 stored, X31 reads zero, one-hot write
// select from the upstream decoder, sticky flag for multi-hot write attempts.
module regfile_32x64 #(
    parameter int WIDTH  = 64,
    parameter bit BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    regfile_32x64_if.slave  rf
);
    logic [WIDTH-1:0] regs [0:30];
    logic             err_q;
    logic             multi_hot;
    logic             any_hot;
    logic             wr_legal;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi_hot = |(rf.wr_sel & (rf.wr_sel - 32'd1));
    assign any_hot   = |rf.wr_sel;
    // A lone select on X31 is legal but has no storage to land in.
    assign wr_legal  = rf.wr_en & any_hot & ~multi_hot & ~rf.wr_sel[31];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 31; i++) begin
                regs[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            if (rf.wr_en && multi_hot) begin
                err_q <= 1'b1;
            end
            for (int i = 0; i < 31; i++) begin
                if (wr_legal && rf.wr_sel[i]) begin
                    regs[i] <= rf.wr_data;
                end
            end
        end
    end

    // A write coinciding with reset is discarded, so it is not forwarded either.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        for (int i = 0; i < 31; i++) begin
            if (rf.rd_addr1 == 5'(i)) begin
                rd1 = regs[i];
            end
            if (rf.rd_addr2 == 5'(i)) begin
                rd2 = regs[i];
            end
        end
        if (BYPASS && wr_legal && !reset) begin
            if (rf.rd_addr1 != 5'd31 && rf.wr_sel[rf.rd_addr1]) begin
                rd1 = rf.wr_data;
            end
            if (rf.rd_addr2 != 5'd31 && rf.wr_sel[rf.rd_addr2]) begin
                rd2 = rf.wr_data;
            end
        end
    end

    assign rf.rd_data1      = rd1;
    assign rf.rd_data2      = rd2;
    assign rf.err_multi_hot = err_q;
endmodule

// File: tb/tb_regfile_32x64.sv
// Scoreboard bench for regfile_32x64: the driver pushes expected read/flag values
// from an array-based reference model, and a negedge monitor pops and compares.
module tb_regfile_32x64;
    localparam int WIDTH  = 64;
    localparam bit BYPASS = 1'b1;

    typedef struct {
        logic [WIDTH-1:0] exp1;
        logic [WIDTH-1:0] exp2;
        logic             experr;
        string            tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    regfile_32x64_if #(.WIDTH(WIDTH)) rf_if ();

    regfile_32x64 #(.WIDTH(WIDTH), .BYPASS(BYPASS)) dut (
        .clk   (clk),
        .reset (reset),
        .rf    (rf_if)
    );

    always #5 clk = ~clk;

    exp_t             sb_q[$];
    logic [WIDTH-1:0] model [0:30];
    logic             model_err;
    int               n_checks = 0;
    int               n_fail   = 0;

    function automatic logic [WIDTH-1:0] model_read(input logic [4:0] addr, input logic rst,
                                                    input logic en, input logic [31:0] sel,
                                                    input logic [WIDTH-1:0] data);
        logic legal;
        if (addr == 5'd31) return '0;
        legal = en && ($countones(sel) == 1) && !sel[31];
        if (BYPASS && legal && !rst && sel[addr]) return data;
        return model[addr];
    endfunction

    task automatic model_edge(input logic rst, input logic en, input logic [31:0] sel,
                              input logic [WIDTH-1:0] data);
        if (rst) begin
            for (int i = 0; i < 31; i++) model[i] = '0;
            model_err = 1'b0;
        end else if (en) begin
            if ($countones(sel) > 1) model_err = 1'b1;
            else if ($countones(sel) == 1 && !sel[31]) begin
                for (int i = 0; i < 31; i++) if (sel[i]) model[i] = data;
            end
        end
    endtask

    task automatic cycle(input string tag, input logic rst, input logic en,
                         input logic [31:0] sel, input logic [WIDTH-1:0] data,
                         input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        reset          = rst;
        rf_if.wr_en    = en;
        rf_if.wr_sel   = sel;
        rf_if.wr_data  = data;
        rf_if.rd_addr1 = a1;
        rf_if.rd_addr2 = a2;
        e.exp1   = model_read(a1, rst, en, sel, data);
        e.exp2   = model_read(a2, rst, en, sel, data);
        e.experr = model_err;
        e.tag    = tag;
        sb_q.push_back(e);
        @(posedge clk);
        model_edge(rst, en, sel, data);
        #1;
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_checks++;
            if (rf_if.rd_data1 !== e.exp1) begin
                n_fail++;
                $display("FAIL %s rd_data1 addr=%0d got=%h exp=%h", e.tag, rf_if.rd_addr1, rf_if.rd_data1, e.exp1);
            end
            n_checks++;
            if (rf_if.rd_data2 !== e.exp2) begin
                n_fail++;
                $display("FAIL %s rd_data2 addr=%0d got=%h exp=%h", e.tag, rf_if.rd_addr2, rf_if.rd_data2, e.exp2);
            end
            n_checks++;
            if (rf_if.err_multi_hot !== e.experr) begin
                n_fail++;
                $display("FAIL %s err_multi_hot got=%b exp=%b", e.tag, rf_if.err_multi_hot, e.experr);
            end
        end
    end

    initial begin
        logic [31:0]      sel;
        logic [WIDTH-1:0] data;
        logic             en;
        logic             rst;
        int               kind;

        reset          = 1'b1;
        rf_if.wr_en    = 1'b0;
        rf_if.wr_sel   = '0;
        rf_if.wr_data  = '0;
        rf_if.rd_addr1 = '0;
        rf_if.rd_addr2 = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 31; i++) model[i] = '0;
        model_err = 1'b0;

        for (int i = 0; i < 32; i++)
            cycle("reset_read", 1'b0, 1'b0, 32'h0, '0, 5'(i), 5'(31 - i));

        cycle("wr_x5", 1'b0, 1'b1, 32'h1 << 5, 64'h0123_4567_89AB_CDEF, 5'd5, 5'd5);
        cycle("rd_x5", 1'b0, 1'b0, 32'h0, '0, 5'd5, 5'd5);

        cycle("wr_x31", 1'b0, 1'b1, 32'h8000_0000, '1, 5'd31, 5'd0);
        for (int i = 0; i < 31; i += 2)
            cycle("after_x31", 1'b0, 1'b0, 32'h0, '0, 5'(i), 5'(i + 1));

        cycle("multi_hot", 1'b0, 1'b1, 32'h0000_0003, 64'hFACE, 5'd0, 5'd1);
        for (int i = 0; i < 11; i++)
            cycle("err_sticky", 1'b0, 1'b0, 32'h0, '0, 5'd0, 5'd1);
        cycle("err_reset", 1'b1, 1'b0, 32'h0, '0, 5'd5, 5'd1);
        cycle("err_cleared", 1'b0, 1'b0, 32'h0, '0, 5'd5, 5'd31);

        cycle("wr_en_low", 1'b0, 1'b0, 32'h1 << 7, 64'hDEAD, 5'd7, 5'd7);
        cycle("wr_en_low_all", 1'b0, 1'b0, 32'hFFFF_FFFF, '1, 5'd7, 5'd0);
        cycle("after_en_low", 1'b0, 1'b0, 32'h0, '0, 5'd7, 5'd0);

        cycle("wr_during_reset", 1'b1, 1'b1, 32'h1 << 3, 64'hAA, 5'd4, 5'd2);
        cycle("wr_after_reset", 1'b0, 1'b1, 32'h1 << 3, 64'hBB, 5'd3, 5'd3);
        cycle("rd_x3", 1'b0, 1'b1, 32'h1 << 3, 64'hCC, 5'd3, 5'd4);
        cycle("rd_x3_last", 1'b0, 1'b0, 32'h0, '0, 5'd3, 5'd3);

        for (int n = 0; n < 600; n++) begin
            kind = $urandom_range(0, 19);
            if (kind < 14)      sel = 32'h1 << $urandom_range(0, 31);
            else if (kind < 16) sel = 32'h0;
            else if (kind < 18) sel = (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31));
            else                sel = $urandom;
            data = {$urandom, $urandom};
            en   = ($urandom_range(0, 3) != 0);
            rst  = ($urandom_range(0, 39) == 0);
            cycle("random", rst, en, sel, data, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        rf_if.wr_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
